hazard_stall_ctrl: RTL and testbench

- Produces the stall/bubble/flush controls consumed by the pipeline registers: `stall_decode` into the ID/EX register, plus hold/squash signals for PC and IF/ID.
- Detects RAW hazards between the ID-stage sources and in-flight writers in EX and MEM.
- Sequences multicycle data-memory waits and a post-siic/rti fetch drain.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout error.

---
 rtl/hazard_stall_ctrl_pkg.sv | 20 ++
 rtl/hazard_stall_ctrl_raw_cmp.sv | 12 +
 rtl/hazard_stall_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard/stall controller.
// Opcodes are the EX-stage opcode field [15:11].
package hazard_stall_ctrl_pkg;

   localparam logic [4:0]  OP_SIIC   = 5'b00010;
   localparam logic [4:0]  OP_RTI    = 5'b00011;
   localparam logic [15:0] NOP_INSTR = 16'h0800;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2
   } state_t;

   // siic and rti both redirect the PC and need the fetch drain afterwards.
   function automatic logic is_exc_op(input logic [4:0] op);
      return (op == OP_SIIC) || (op == OP_RTI);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_raw_cmp.sv
// One source-vs-destination RAW compare; R0 is matched like any other register.
module raw_cmp (
   input  logic [2:0] src,
   input  logic       src_valid,
   input  logic [2:0] dst,
   input  logic       dst_write,
   output logic       match
);

   assign match = dst_write & src_valid & (src == dst);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush/freeze controller: RAW hazard detection, data-memory wait
// sequencing, post-exception fetch drain, stall-cycle counter and timeout flag.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int FWD_EN      = 1,
   parameter int DRAIN_CYC   = 2,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  id_rs,
   input  logic [2:0]  id_rt,
   input  logic        id_rs_valid,
   input  logic        id_rt_valid,
   input  logic [2:0]  ex_write_sel,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic [2:0]  mem_write_sel,
   input  logic        mem_reg_write,
   input  logic [4:0]  ex_opcode,
   input  logic        branch_taken,
   input  logic        dmem_stall,
   output logic        stall_decode,
   output logic        stall_fetch,
   output logic        flush_fetch,
   output logic        freeze,
   output logic [15:0] stall_cnt,
   output logic        err
);

   localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
   localparam logic [2:0]        DRAIN_LOAD = 3'(DRAIN_CYC - 1);

   // Compare lanes: 0 = rs/EX, 1 = rt/EX, 2 = rs/MEM, 3 = rt/MEM.
   logic [3:0][2:0] cmp_src;
   logic [3:0][2:0] cmp_dst;
   logic [3:0]      cmp_src_valid;
   logic [3:0]      cmp_dst_write;
   logic [3:0]      cmp_match;

   assign cmp_src       = {id_rt, id_rs, id_rt, id_rs};
   assign cmp_src_valid = {id_rt_valid, id_rs_valid, id_rt_valid, id_rs_valid};
   assign cmp_dst       = {mem_write_sel, mem_write_sel, ex_write_sel, ex_write_sel};
   assign cmp_dst_write = {mem_reg_write, mem_reg_write, ex_reg_write, ex_reg_write};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cmp
         raw_cmp u_raw_cmp (
            .src       (cmp_src[gi]),
            .src_valid (cmp_src_valid[gi]),
            .dst       (cmp_dst[gi]),
            .dst_write (cmp_dst_write[gi]),
            .match     (cmp_match[gi])
         );
      end
   endgenerate

   logic raw_x;
   logic raw_m;
   logic hz;

   assign raw_x = cmp_match[0] | cmp_match[1];
   assign raw_m = cmp_match[2] | cmp_match[3];
   assign hz    = (FWD_EN != 0) ? (raw_x & ex_mem_read) : (raw_x | raw_m);

   state_t            state_reg, state_next;
   logic [2:0]        drain_reg, drain_next;
   logic [WAIT_W-1:0] wait_reg, wait_next;
   logic              err_reg, err_next;
   logic [15:0]       stall_cnt_reg;

   logic stall_decode_next;
   logic stall_fetch_next;
   logic flush_fetch_next;
   logic freeze_next;
   logic run_rules;

   always_comb begin
      state_next        = state_reg;
      drain_next        = drain_reg;
      wait_next         = wait_reg;
      err_next          = err_reg;
      stall_decode_next = 1'b0;
      stall_fetch_next  = 1'b0;
      flush_fetch_next  = 1'b0;
      freeze_next       = 1'b0;
      run_rules         = 1'b0;

      case (state_reg)
         ST_RUN: run_rules = 1'b1;
         ST_MEM_WAIT: begin
            if (dmem_stall) begin
               freeze_next = 1'b1;
               if (wait_reg != WAIT_MAX) wait_next = wait_reg + 1'b1;
               if (wait_reg == WAIT_LAST) err_next = 1'b1;
            end else begin
               // Memory released: fall straight through to the RUN rules this cycle.
               wait_next  = '0;
               state_next = ST_RUN;
               run_rules  = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (dmem_stall) begin
               freeze_next = 1'b1;
            end else begin
               stall_decode_next = 1'b1;
               stall_fetch_next  = 1'b1;
               if (drain_reg == 3'd0) state_next = ST_RUN;
               else drain_next = drain_reg - 3'd1;
            end
         end
         default: state_next = ST_RUN;
      endcase

      if (run_rules) begin
         if (dmem_stall) begin
            freeze_next = 1'b1;
            state_next  = ST_MEM_WAIT;
         end else if (is_exc_op(ex_opcode)) begin
            flush_fetch_next = 1'b1;
            state_next       = ST_DRAIN;
            drain_next       = DRAIN_LOAD;
         end else if (branch_taken) begin
            flush_fetch_next  = 1'b1;
            stall_decode_next = 1'b1;
         end else if (hz) begin
            stall_decode_next = 1'b1;
            stall_fetch_next  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_RUN;
         drain_reg     <= 3'd0;
         wait_reg      <= '0;
         err_reg       <= 1'b0;
         stall_cnt_reg <= 16'd0;
      end else begin
         state_reg <= state_next;
         drain_reg <= drain_next;
         wait_reg  <= wait_next;
         err_reg   <= err_next;
         if (stall_decode_next && !freeze_next && (stall_cnt_reg != 16'hFFFF))
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   // Controls are forced low while reset is held, independent of the inputs.
   assign stall_decode = rst & stall_decode_next;
   assign stall_fetch  = rst & stall_fetch_next;
   assign flush_fetch  = rst & flush_fetch_next;
   assign freeze       = rst & freeze_next;
   assign stall_cnt    = stall_cnt_reg;
   assign err          = err_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: dut_a (forwarding, short timeout) and dut_b (no forwarding)
// share one stimulus; ctl vectors are {stall_decode, stall_fetch, flush_fetch, freeze}.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] id_rs, id_rt, ex_write_sel, mem_write_sel;
   logic       id_rs_valid, id_rt_valid, ex_reg_write, ex_mem_read, mem_reg_write;
   logic [4:0] ex_opcode;
   logic       branch_taken, dmem_stall;

   logic        a_sd, a_sf, a_ff, a_fz, a_err;
   logic [15:0] a_cnt;
   logic        b_sd, b_sf, b_ff, b_fz, b_err;
   logic [15:0] b_cnt;
   logic [3:0]  ctl_a, ctl_b;

   int checks = 0;
   int errors = 0;

   localparam logic [4:0] OPC_SIIC = 5'b00010;
   localparam logic [4:0] OPC_RTI  = 5'b00011;

   assign ctl_a = {a_sd, a_sf, a_ff, a_fz};
   assign ctl_b = {b_sd, b_sf, b_ff, b_fz};

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.FWD_EN(1), .DRAIN_CYC(2), .MEM_TIMEOUT(4)) dut_a (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
      .ex_write_sel(ex_write_sel), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .mem_write_sel(mem_write_sel), .mem_reg_write(mem_reg_write),
      .ex_opcode(ex_opcode), .branch_taken(branch_taken), .dmem_stall(dmem_stall),
      .stall_decode(a_sd), .stall_fetch(a_sf), .flush_fetch(a_ff), .freeze(a_fz),
      .stall_cnt(a_cnt), .err(a_err)
   );

   hazard_stall_ctrl #(.FWD_EN(0), .DRAIN_CYC(2), .MEM_TIMEOUT(64)) dut_b (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
      .ex_write_sel(ex_write_sel), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .mem_write_sel(mem_write_sel), .mem_reg_write(mem_reg_write),
      .ex_opcode(ex_opcode), .branch_taken(branch_taken), .dmem_stall(dmem_stall),
      .stall_decode(b_sd), .stall_fetch(b_sf), .flush_fetch(b_ff), .freeze(b_fz),
      .stall_cnt(b_cnt), .err(b_err)
   );

   task automatic idle();
      id_rs = 3'd0; id_rt = 3'd0; id_rs_valid = 1'b0; id_rt_valid = 1'b0;
      ex_write_sel = 3'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      mem_write_sel = 3'd0; mem_reg_write = 1'b0;
      ex_opcode = 5'd0; branch_taken = 1'b0; dmem_stall = 1'b0;
   endtask

   task automatic load_use();
      idle();
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_sel = 3'd3;
      id_rs = 3'd3; id_rs_valid = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      $display("scenario test_reset");
      idle();
      rst = 1'b0;
      dmem_stall = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (ctl_a !== 4'b0000) begin errors++; $display("FAIL reset_ctl_a: got %b expected 0000", ctl_a); end
      checks++; if (ctl_b !== 4'b0000) begin errors++; $display("FAIL reset_ctl_b: got %b expected 0000", ctl_b); end
      checks++; if (a_cnt !== 16'd0 || a_err !== 1'b0) begin errors++; $display("FAIL reset_cnt_err: got cnt=%0d err=%b expected 0/0", a_cnt, a_err); end
      rst = 1'b1;
      idle();
   endtask

   task automatic test_load_use();
      $display("scenario test_load_use");
      do_reset();
      @(negedge clk); load_use(); #1;
      checks++; if (ctl_a !== 4'b1100) begin errors++; $display("FAIL load_use_ctl_a: got %b expected 1100", ctl_a); end
      checks++; if (ctl_b !== 4'b1100) begin errors++; $display("FAIL load_use_ctl_b: got %b expected 1100", ctl_b); end
      checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL load_use_cnt0: got %0d expected 0", a_cnt); end
      @(negedge clk); idle(); #1;
      checks++; if (ctl_a !== 4'b0000) begin errors++; $display("FAIL load_use_clear: got %b expected 0000", ctl_a); end
      checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt1: got %0d expected 1", a_cnt); end
      @(negedge clk); load_use(); ex_mem_read = 1'b0; #1;
      checks++; if (ctl_a !== 4'b0000) begin errors++; $display("FAIL fwd_alu_ctl_a: got %b expected 0000", ctl_a); end
      checks++; if (ctl_b !== 4'b1100) begin errors++; $display("FAIL nofwd_alu_ctl_b: got %b expected 1100", ctl_b); end
      @(negedge clk); idle(); #1;
      checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL fwd_alu_cnt: got %0d expected 1", a_cnt); end
   endtask

   task automatic test_no_forward();
      $display("scenario test_no_forward");
      do_reset();
      @(negedge clk); idle(); mem_reg_write = 1'b1; mem_write_sel = 3'd5; id_rt = 3'd5; id_rt_valid = 1'b1; #1;
      checks++; if (ctl_b !== 4'b1100) begin errors++; $display("FAIL mem_raw_ctl_b: got %b expected 1100", ctl_b); end
      checks++; if (ctl_a !== 4'b0000) begin errors++; $display("FAIL mem_raw_ctl_a: got %b expected 0000", ctl_a); end
      @(negedge clk); id_rt_valid = 1'b0; #1;
      checks++; if (ctl_b !== 4'b0000) begin errors++; $display("FAIL mem_raw_invalid: got %b expected 0000", ctl_b); end
      @(negedge clk); idle(); mem_reg_write = 1'b1; mem_write_sel = 3'd0; id_rs = 3'd0; id_rs_valid = 1'b1; #1;
      checks++; if (ctl_b !== 4'b1100) begin errors++; $display("FAIL r0_raw: got %b expected 1100", ctl_b); end
      @(negedge clk); mem_reg_write = 1'b0; #1;
      checks++; if (ctl_b !== 4'b0000) begin errors++; $display("FAIL r0_nowrite: got %b expected 0000", ctl_b); end
   endtask

   task automatic test_mem_wait();
      $display("scenario test_mem_wait");
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); idle(); dmem_stall = 1'b1; #1;
         checks++; if (ctl_a !== 4'b0001) begin errors++; $display("FAIL mem_wait_freeze%0d: got %b expected 0001", i, ctl_a); end
      end
      @(negedge clk); load_use(); #1;
      checks++; if (ctl_a !== 4'b1100) begin errors++; $display("FAIL mem_wait_exit_run: got %b expected 1100", ctl_a); end
      @(negedge clk); idle(); #1;
      checks++; if (ctl_a !== 4'b0000 || a_err !== 1'b0) begin errors++; $display("FAIL mem_wait_done: got ctl=%b err=%b expected 0000/0", ctl_a, a_err); end
      checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL mem_wait_cnt: got %0d expected 1", a_cnt); end
   endtask

   task automatic test_timeout();
      $display("scenario test_timeout");
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); idle(); dmem_stall = 1'b1; #1;
         if (i == 3) begin
            checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", a_err); end
         end
      end
      @(negedge clk); idle(); #1;
      checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b expected 1", a_err); end
      checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL timeout_long_b: got %b expected 0", b_err); end
      checks++; if (ctl_a !== 4'b0000) begin errors++; $display("FAIL timeout_release: got %b expected 0000", ctl_a); end
      repeat (2) @(negedge clk); #1;
      checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", a_err); end
   endtask

   task automatic test_drain();
      $display("scenario test_drain");
      do_reset();
      @(negedge clk); idle(); ex_opcode = OPC_RTI; #1;
      checks++; if (ctl_a !== 4'b0010) begin errors++; $display("FAIL drain_flush: got %b expected 0010", ctl_a); end
      @(negedge clk); idle(); branch_taken = 1'b1; #1;
      checks++; if (ctl_a !== 4'b1100) begin errors++; $display("FAIL drain_cyc1_branch: got %b expected 1100", ctl_a); end
      @(negedge clk); idle(); #1;
      checks++; if (ctl_a !== 4'b1100) begin errors++; $display("FAIL drain_cyc2: got %b expected 1100", ctl_a); end
      @(negedge clk); idle(); #1;
      checks++; if (ctl_a !== 4'b0000) begin errors++; $display("FAIL drain_done: got %b expected 0000", ctl_a); end
      checks++; if (a_cnt !== 16'd2) begin errors++; $display("FAIL drain_cnt: got %0d expected 2", a_cnt); end
   endtask

   task automatic test_exc_and_branch();
      $display("scenario test_exc_and_branch");
      do_reset();
      @(negedge clk); idle(); ex_opcode = OPC_SIIC; branch_taken = 1'b1; #1;
      checks++; if (ctl_a !== 4'b0010) begin errors++; $display("FAIL siic_branch_ctl: got %b expected 0010", ctl_a); end
      @(negedge clk); idle(); #1;
      checks++; if (ctl_a !== 4'b1100) begin errors++; $display("FAIL siic_branch_drain: got %b expected 1100", ctl_a); end
   endtask

   task automatic test_drain_freeze();
      $display("scenario test_drain_freeze");
      do_reset();
      @(negedge clk); idle(); ex_opcode = OPC_RTI; #1;
      @(negedge clk); idle(); #1;
      checks++; if (ctl_a !== 4'b1100) begin errors++; $display("FAIL dfz_cyc1: got %b expected 1100", ctl_a); end
      @(negedge clk); idle(); dmem_stall = 1'b1; #1;
      checks++; if (ctl_a !== 4'b0001) begin errors++; $display("FAIL dfz_freeze: got %b expected 0001", ctl_a); end
      @(negedge clk); idle(); #1;
      checks++; if (ctl_a !== 4'b1100) begin errors++; $display("FAIL dfz_cyc2: got %b expected 1100", ctl_a); end
      @(negedge clk); idle(); #1;
      checks++; if (ctl_a !== 4'b0000 || a_cnt !== 16'd2) begin errors++; $display("FAIL dfz_done: got ctl=%b cnt=%0d expected 0000/2", ctl_a, a_cnt); end
   endtask

   task automatic test_branch_hz();
      $display("scenario test_branch_hz");
      do_reset();
      @(negedge clk); load_use(); branch_taken = 1'b1; #1;
      checks++; if (ctl_a !== 4'b1010) begin errors++; $display("FAIL branch_hz_ctl: got %b expected 1010", ctl_a); end
      @(negedge clk); idle(); #1;
      checks++; if (ctl_a !== 4'b0000 || a_cnt !== 16'd1) begin errors++; $display("FAIL branch_hz_after: got ctl=%b cnt=%0d expected 0000/1", ctl_a, a_cnt); end
   endtask

   task automatic test_reset_mid_wait();
      $display("scenario test_reset_mid_wait");
      do_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); load_use(); #1;
      end
      @(negedge clk); idle(); dmem_stall = 1'b1; #1;
      checks++; if (ctl_a !== 4'b0001 || a_cnt !== 16'd7) begin errors++; $display("FAIL rmw_pre: got ctl=%b cnt=%0d expected 0001/7", ctl_a, a_cnt); end
      @(negedge clk); #1;
      checks++; if (ctl_a !== 4'b0001) begin errors++; $display("FAIL rmw_wait: got %b expected 0001", ctl_a); end
      #2 rst = 1'b0;
      #1;
      checks++; if (ctl_a !== 4'b0000 || a_cnt !== 16'd0) begin errors++; $display("FAIL rmw_async: got ctl=%b cnt=%0d expected 0000/0", ctl_a, a_cnt); end
      @(negedge clk); rst = 1'b1; idle(); #1;
      checks++; if (ctl_a !== 4'b0000) begin errors++; $display("FAIL rmw_release: got %b expected 0000", ctl_a); end
      @(negedge clk); load_use(); #1;
      checks++; if (ctl_a !== 4'b1100 || a_cnt !== 16'd0) begin errors++; $display("FAIL rmw_run: got ctl=%b cnt=%0d expected 1100/0", ctl_a, a_cnt); end
      @(negedge clk); idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_load_use();
      test_no_forward();
      test_mem_wait();
      test_timeout();
      test_drain();
      test_exc_and_branch();
      test_drain_freeze();
      test_branch_hz();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
